// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared timing constants and window helper for the VGA timing slice.
package vga_timing_pkg;
  `include "vga_params.vh"

  function automatic logic in_window(input int value, input int lo, input int hi);
    return (value >= lo) && (value < hi);
  endfunction
endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one raster axis: position counter with registered sync/visible flags.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int VISIBLE = 640,
  parameter int FRONT   = 16,
  parameter int SYNC    = 96,
  parameter int BACK    = 48,
  parameter int W       = $clog2(VISIBLE + FRONT + SYNC + BACK)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         step,
  output logic [W-1:0] count,
  output logic         sync,
  output logic         visible,
  output logic         wrap
);
  localparam int TOTAL      = VISIBLE + FRONT + SYNC + BACK;
  localparam int SYNC_START = VISIBLE + FRONT;

  logic [W-1:0] count_next;

  // Out-of-range counts are treated as the last position so they wrap home.
  assign wrap       = int'(count) >= TOTAL - 1;
  assign count_next = wrap ? '0 : count + W'(1);

  // Flags are taken from the next count so they line up with the count they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      sync    <= 1'b1;
      visible <= 1'b1;
    end else if (step) begin
      count   <= count_next;
      sync    <= !in_window(int'(count_next), SYNC_START, SYNC_START + SYNC);
      visible <= in_window(int'(count_next), 0, VISIBLE);
    end
  end
endmodule

// File: rtl/vga_params.vh
// rtl/vga_params.vh - default 640x480@60 timing constants and sync window bounds.
`ifndef VGA_PARAMS_VH
`define VGA_PARAMS_VH
localparam int VGA_WIDTH     = 640;
localparam int VGA_HEIGHT    = 480;
localparam int H_FRONT_PORCH = 16;
localparam int H_SYNC_PULSE  = 96;
localparam int H_BACK_PORCH  = 48;
localparam int V_FRONT_PORCH = 10;
localparam int V_SYNC_PULSE  = 2;
localparam int V_BACK_PORCH  = 33;
localparam int FRAME_BITS    = 5;

localparam int H_TOTAL      = VGA_WIDTH + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH;
localparam int V_TOTAL      = VGA_HEIGHT + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH;
localparam int H_SYNC_START = VGA_WIDTH + H_FRONT_PORCH;
localparam int H_SYNC_END   = H_SYNC_START + H_SYNC_PULSE;
localparam int V_SYNC_START = VGA_HEIGHT + V_FRONT_PORCH;
localparam int V_SYNC_END   = V_SYNC_START + V_SYNC_PULSE;
`endif

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - 640x480@60 raster timing source with line/frame strobes and frame counter.
// Define VGA_TIMING_PIPE_EN to delay hsync/vsync/active by one further pixel step.
module vga_timing #(
  parameter int VGA_WIDTH       = vga_timing_pkg::VGA_WIDTH,
  parameter int VGA_HEIGHT      = vga_timing_pkg::VGA_HEIGHT,
  parameter int H_FRONT_PORCH   = vga_timing_pkg::H_FRONT_PORCH,
  parameter int H_SYNC_PULSE    = vga_timing_pkg::H_SYNC_PULSE,
  parameter int H_BACK_PORCH    = vga_timing_pkg::H_BACK_PORCH,
  parameter int V_FRONT_PORCH   = vga_timing_pkg::V_FRONT_PORCH,
  parameter int V_SYNC_PULSE    = vga_timing_pkg::V_SYNC_PULSE,
  parameter int V_BACK_PORCH    = vga_timing_pkg::V_BACK_PORCH,
  parameter int FRAME_BITS      = vga_timing_pkg::FRAME_BITS,
  localparam int X_BITS = $clog2(VGA_WIDTH + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH),
  localparam int Y_BITS = $clog2(VGA_HEIGHT + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pixel_ce,
  output logic [X_BITS-1:0]     pixel_x,
  output logic [Y_BITS-1:0]     pixel_y,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  active,
  output logic                  line_start,
  output logic                  frame_start,
  output logic [FRAME_BITS-1:0] frame_counter
);
  logic h_sync, h_visible, h_wrap;
  logic v_sync, v_visible, v_wrap;
  logic line_step, frame_step;

  assign line_step  = pixel_ce & h_wrap;
  assign frame_step = line_step & v_wrap;

  vga_axis_counter #(
    .VISIBLE(VGA_WIDTH),
    .FRONT  (H_FRONT_PORCH),
    .SYNC   (H_SYNC_PULSE),
    .BACK   (H_BACK_PORCH),
    .W      (X_BITS)
  ) u_h_axis (
    .clk    (clk),
    .rst_n  (rst_n),
    .step   (pixel_ce),
    .count  (pixel_x),
    .sync   (h_sync),
    .visible(h_visible),
    .wrap   (h_wrap)
  );

  vga_axis_counter #(
    .VISIBLE(VGA_HEIGHT),
    .FRONT  (V_FRONT_PORCH),
    .SYNC   (V_SYNC_PULSE),
    .BACK   (V_BACK_PORCH),
    .W      (Y_BITS)
  ) u_v_axis (
    .clk    (clk),
    .rst_n  (rst_n),
    .step   (line_step),
    .count  (pixel_y),
    .sync   (v_sync),
    .visible(v_visible),
    .wrap   (v_wrap)
  );

  // Strobes are 0 out of reset so the first pulse comes only after a real wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_start    <= 1'b0;
      frame_start   <= 1'b0;
      frame_counter <= '0;
    end else begin
      line_start  <= line_step;
      frame_start <= frame_step;
      if (frame_step) begin
        frame_counter <= frame_counter + FRAME_BITS'(1);
      end
    end
  end

`ifdef VGA_TIMING_PIPE_EN
  logic hsync_q, vsync_q, active_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
      active_q <= 1'b1;
    end else if (pixel_ce) begin
      hsync_q  <= h_sync;
      vsync_q  <= v_sync;
      active_q <= h_visible & v_visible;
    end
  end

  assign hsync  = hsync_q;
  assign vsync  = vsync_q;
  assign active = active_q;
`else
  assign hsync  = h_sync;
  assign vsync  = v_sync;
  assign active = h_visible & v_visible;
`endif
endmodule
